// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// glyph table, digit count, snapshot record and pin polarity helper.
package seg7_pkg;

    localparam int unsigned N_DIGITS = 8;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}; A-F shown as A,b,C,d,E,F.
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [31:0]         time_data;
        logic [N_DIGITS-1:0] blank;
        logic [N_DIGITS-1:0] blink;
        logic [N_DIGITS-1:0] dp;
    } snap_t;

    // Maps a logical "on" bit to the pin level for the chosen polarity.
    function automatic logic to_pin(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG7[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous input
// snapshot, per-digit blank/blink/dp, PWM brightness and registered outputs.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] time_data,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    input  logic [2:0]  brightness,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic        AL        = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0]   pre;
    logic [2:0]         idx;
    logic [2:0]         pwm;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    snap_t              snap;

    logic               slot_end;
    logic               frame_wrap;
    logic               blink_wrap;
    logic [3:0]         nibble;
    logic [6:0]         glyph;
    logic               lit;
    logic [7:0]         an_next;
    logic [6:0]         seg_next;
    logic               dp_next;

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        slot_end   = (pre == PRE_W'(DIV - 1));
        frame_wrap = slot_end && (idx == 3'd7);
        blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
        nibble     = snap.time_data[{idx, 2'b00} +: 4];

        // pre==0 is the per-slot dead clock that keeps the previous digit from ghosting.
        lit = (pre != '0) && (pwm <= brightness) && !snap.blank[idx]
              && !(snap.blink[idx] && blink_phase);

        an_next  = '0;
        seg_next = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            an_next[i] = to_pin(lit && (idx == 3'(i)), AL);
        end
        for (int unsigned i = 0; i < 7; i++) begin
            seg_next[i] = to_pin(lit && glyph[i], AL);
        end
        dp_next = to_pin(lit && snap.dp[idx], AL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre         <= '0;
            idx         <= '0;
            pwm         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= '0;
            an          <= {8{AL}};
            seg         <= {7{AL}};
            dp          <= AL;
            frame_start <= 1'b0;
        end else begin
            pwm <= pwm + 3'd1;

            if (slot_end) begin
                pre <= '0;
                idx <= idx + 3'd1;
            end else begin
                pre <= pre + PRE_W'(1);
            end

            if (frame_wrap) begin
                snap <= '{time_data: time_data, blank: blank_mask,
                          blink: blink_mask, dp: dp_mask};
            end
            frame_start <= frame_wrap;

            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: directed phases plus random
// stimulus, checked every clock against a time-indexed behavioural model.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] time_data = '0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  dp_mask = '0;
    logic [2:0]  brightness = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model: k counts clocks since reset release; with DIV=8 the slot position,
    // digit and pwm all follow from k, and the blink phase flips every 16 clocks.
    int unsigned k = 0;
    logic [31:0] m_time = '0;
    logic [7:0]  m_blank = '0;
    logic [7:0]  m_blink = '0;
    logic [7:0]  m_dp = '0;

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_scan_display #(
        .CLK_HZ     (800),
        .SCAN_HZ    (100),
        .BLINK_HZ   (25),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .time_data   (time_data),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic rst);
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fs;
        int unsigned slot_pos;
        int unsigned digit;
        int unsigned pwm_val;
        logic        phase;
        logic        lit;
        logic [3:0]  nib;
        if (rst) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_fs  = 1'b0;
        end else begin
            slot_pos = k % 8;
            digit    = (k / 8) % 8;
            pwm_val  = k % 8;
            phase    = ((k / 16) % 2) == 1;
            lit = (slot_pos != 0) && (pwm_val <= int'(brightness)) &&
                  !m_blank[digit] && !(m_blink[digit] && phase);
            nib   = m_time[4*digit +: 4];
            e_an  = lit ? ~(8'h01 << digit) : 8'hFF;
            e_seg = lit ? ~glyph_tab[nib] : 7'h7F;
            e_dp  = !(lit && m_dp[digit]);
            e_fs  = ((k + 1) % 64) == 0;
        end
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            k = 0;
            m_time = '0; m_blank = '0; m_blink = '0; m_dp = '0;
        end else begin
            if (((k + 1) % 64) == 0) begin
                m_time = time_data; m_blank = blank_mask;
                m_blink = blink_mask; m_dp = dp_mask;
            end
            k++;
        end
        tests++;
        assert (an === e_an) else begin
            fails++;
            $error("FAIL an k=%0d got %h expected %h", k, an, e_an);
        end
        tests++;
        assert (seg === e_seg) else begin
            fails++;
            $error("FAIL seg k=%0d got %h expected %h", k, seg, e_seg);
        end
        tests++;
        assert (dp === e_dp) else begin
            fails++;
            $error("FAIL dp k=%0d got %b expected %b", k, dp, e_dp);
        end
        tests++;
        assert (frame_start === e_fs) else begin
            fails++;
            $error("FAIL frame_start k=%0d got %b expected %b", k, frame_start, e_fs);
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        // Reset held three clocks.
        for (int i = 0; i < 3; i++) tick(1'b1);

        // Basic scan of a known pattern.
        time_data = 32'h12345678; brightness = 3'd7;
        run(140);

        // Mid-frame data change at digit 3 must wait for the next snapshot.
        while ((k % 64) != 26) tick(1'b0);
        time_data = 32'h0;
        run(130);

        // Blanking and decimal point.
        time_data = 32'hABCDEF90; blank_mask = 8'h80; dp_mask = 8'h01;
        run(128);

        // Brightness extremes.
        brightness = 3'd0;
        run(64);
        brightness = 3'd3;
        run(64);

        // Blinking digit 0.
        brightness = 3'd7; blank_mask = 8'h00; blink_mask = 8'h01;
        run(128);

        // Random inputs; brightness may change on any clock.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) brightness = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 30) == 0) begin
                time_data  = $urandom;
                blank_mask = 8'($urandom);
                blink_mask = 8'($urandom);
                dp_mask    = 8'($urandom);
            end
            tick(1'b0);
        end

        // Reset in the middle of a slot, then resume scanning from digit 0.
        brightness = 3'd7; blank_mask = '0; blink_mask = '0; dp_mask = 8'h0F;
        time_data = 32'h0F1E2D3C;
        while ((k % 8) != 4) tick(1'b0);
        tick(1'b1);
        run(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
